// File: rtl/tod_input_conditioner.sv
// Purpose: front-end for the time-of-day counter: 1 Hz advance strobe, switch sync, debounced set-load.
// Latency: tick_1hz every DIV cycles; load pulse DB_CYCLES+2 cycles after a stable raw sw[8] rise.
// Backpressure: none; tick_1hz and load_* are single-cycle strobes the consumer must take when high.
//
// Ports:
//   clk         board clock, all logic on the rising edge
//   reset       asynchronous, active-high reset
//   sw[9:0]     raw slide switches: [9] hour(1)/minute(0), [8] set request, [7:4] tens, [3:0] units
//   tick_1hz    one-cycle count-enable strobe, suppressed while setting
//   set_active  debounced set level
//   load_hour   one-cycle load of set_hi/set_lo into the hour digits
//   load_minute one-cycle load of set_hi/set_lo into the minute digits
//   set_hi      validated tens digit, held between loads
//   set_lo      validated units digit, held between loads
module tod_input_conditioner #(
  parameter int CLK_HZ    = 50000000,
  parameter int TICK_HZ   = 1,
  parameter int DB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] sw,
  output logic       tick_1hz,
  output logic       set_active,
  output logic       load_hour,
  output logic       load_minute,
  output logic [3:0] set_hi,
  output logic [3:0] set_lo
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int DW  = $clog2(DB_CYCLES);
  localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DB_CYCLES - 1);
  localparam logic [DW-1:0] DCNT_ONE  = DW'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CONF_HIGH = 2'd1,
    HELD      = 2'd2,
    CONF_LOW  = 2'd3
  } db_state_t;

  // Two-flop synchroniser; nothing downstream looks at the raw switches.
  logic [9:0] sync1;
  logic [9:0] ssw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      ssw   <= '0;
    end else begin
      sync1 <= sw;
      ssw   <= sync1;
    end
  end

  // Debounce FSM on ssw[8]
  db_state_t       state, state_nxt;
  logic [DW-1:0]   dcnt, dcnt_nxt;
  logic            fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    fire      = 1'b0;
    unique case (state)
      IDLE: begin
        if (ssw[8]) begin
          state_nxt = CONF_HIGH;
          dcnt_nxt  = DCNT_ONE;
        end
      end
      CONF_HIGH: begin
        if (!ssw[8]) begin
          state_nxt = IDLE;
        end else if (dcnt == DCNT_LAST) begin
          state_nxt = HELD;
          fire      = 1'b1;
        end else begin
          dcnt_nxt = dcnt + 1'b1;
        end
      end
      HELD: begin
        if (!ssw[8]) begin
          state_nxt = CONF_LOW;
          dcnt_nxt  = DCNT_ONE;
        end
      end
      CONF_LOW: begin
        // A return to high here is bounce on release, not a new press: no load.
        if (ssw[8]) begin
          state_nxt = HELD;
        end else if (dcnt == DCNT_LAST) begin
          state_nxt = IDLE;
        end else begin
          dcnt_nxt = dcnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        dcnt_nxt  = '0;
      end
    endcase
  end

  assign set_active = (state == HELD) || (state == CONF_LOW);

  // Digit validation, only consumed on the fire cycle
  logic [3:0] dig_hi;
  logic [3:0] dig_lo;
  logic       lo_ok;
  logic       hour_ok;
  logic       minute_ok;
  logic       dig_ok;

  always_comb begin
    dig_hi    = ssw[7:4];
    dig_lo    = ssw[3:0];
    lo_ok     = (dig_lo <= 4'd9);
    hour_ok   = lo_ok && ((dig_hi < 4'd2) || ((dig_hi == 4'd2) && (dig_lo <= 4'd3)));
    minute_ok = lo_ok && (dig_hi <= 4'd5);
    dig_ok    = ssw[9] ? hour_ok : minute_ok;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_hour   <= 1'b0;
      load_minute <= 1'b0;
      set_hi      <= 4'd0;
      set_lo      <= 4'd0;
    end else begin
      load_hour   <= fire & ssw[9];
      load_minute <= fire & ~ssw[9];
      if (fire) begin
        set_hi <= dig_ok ? dig_hi : 4'd0;
        set_lo <= dig_ok ? dig_lo : 4'd0;
      end
    end
  end

  // Prescaler: parked at 0 while setting so the first tick after release
  // arrives a full DIV cycles later.
  logic [PW-1:0] pcnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt     <= '0;
      tick_1hz <= 1'b0;
    end else if (set_active) begin
      pcnt     <= '0;
      tick_1hz <= 1'b0;
    end else if (pcnt == PCNT_LAST) begin
      pcnt     <= '0;
      tick_1hz <= 1'b1;
    end else begin
      pcnt     <= pcnt + 1'b1;
      tick_1hz <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tod_input_conditioner.sv
module tb_tod_input_conditioner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] sw = '0;
  logic       tick_1hz;
  logic       set_active;
  logic       load_hour;
  logic       load_minute;
  logic [3:0] set_hi;
  logic [3:0] set_lo;

  int checks = 0;
  int errors = 0;

  tod_input_conditioner #(
    .CLK_HZ   (20),
    .TICK_HZ  (1),
    .DB_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw         (sw),
    .tick_1hz   (tick_1hz),
    .set_active (set_active),
    .load_hour  (load_hour),
    .load_minute(load_minute),
    .set_hi     (set_hi),
    .set_lo     (set_lo)
  );

  always #5 clk = ~clk;

  // {tick, set_active, load_hour, load_minute, set_hi, set_lo}
  logic [11:0] obs;
  assign obs = {tick_1hz, set_active, load_hour, load_minute, set_hi, set_lo};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after an edge with reset just released; that
  // edge counts as k=0 for the caller's loop.
  task automatic do_reset(input logic [9:0] s);
    reset = 1'b1;
    sw    = s;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] exp;
    reset = 1'b1;
    sw    = '0;
    step();
    checks++;
    if (obs !== 12'h000) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", obs, 12'h000);
    end
    do_reset(10'h000);
    for (int k = 1; k <= 45; k++) begin
      step();
      exp = {(k % 20 == 0), 11'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL idle_tick k=%0d got=%h exp=%h", k, obs, exp);
      end
    end
  endtask

  task automatic test_set_hour();
    logic [11:0] exp;
    do_reset(10'h223);
    for (int k = 1; k <= 60; k++) begin
      step();
      exp = {(k == 56), (k >= 9 && k < 36), (k == 9), 1'b0,
             (k >= 9) ? 4'd2 : 4'd0, (k >= 9) ? 4'd3 : 4'd0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL set_hour k=%0d got=%h exp=%h", k, obs, exp);
      end
      if (k == 3)  sw[8] = 1'b1;
      if (k == 30) sw[8] = 1'b0;
    end
  endtask

  task automatic test_validation();
    logic [9:0]  sv [8];
    logic [7:0]  ev [8];
    logic [11:0] exp;
    logic        hr;
    sv = '{10'h225, 10'h059, 10'h06A, 10'h224, 10'h219, 10'h00A, 10'h069, 10'h230};
    ev = '{8'h00,   8'h59,   8'h00,   8'h00,   8'h19,   8'h00,   8'h00,   8'h00};
    for (int i = 0; i < 8; i++) begin
      do_reset(sv[i]);
      hr = sv[i][9];
      for (int k = 1; k <= 12; k++) begin
        step();
        exp = {1'b0, (k >= 9), (k == 9) && hr, (k == 9) && !hr,
               (k >= 9) ? ev[i] : 8'h00};
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL validate sw=%h k=%0d got=%h exp=%h", sv[i], k, obs, exp);
        end
        if (k == 3) sw[8] = 1'b1;
      end
    end
  endtask

  task automatic test_bounce();
    logic [11:0] exp;
    do_reset(10'h000);
    for (int k = 1; k <= 45; k++) begin
      step();
      exp = {(k % 20 == 0), 11'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL bounce k=%0d got=%h exp=%h", k, obs, exp);
      end
      if (k == 3) sw[8] = 1'b1;
      if (k == 5) sw[8] = 1'b0;
      if (k == 6) sw[8] = 1'b1;
      if (k == 8) sw[8] = 1'b0;
    end
  endtask

  task automatic test_held_glitch();
    logic [11:0] exp;
    do_reset(10'h212);
    for (int k = 1; k <= 30; k++) begin
      step();
      exp = {1'b0, (k >= 9), (k == 9), 1'b0,
             (k >= 9) ? 4'd1 : 4'd0, (k >= 9) ? 4'd2 : 4'd0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL held_glitch k=%0d got=%h exp=%h", k, obs, exp);
      end
      if (k == 3)  sw[8] = 1'b1;
      if (k == 12) sw[8] = 1'b0;
      if (k == 14) sw[8] = 1'b1;
      if (k == 18) begin
        sw[9]   = 1'b0;
        sw[7:0] = 8'h45;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] exp;
    do_reset(10'h208);
    for (int k = 1; k <= 7; k++) begin
      step();
      checks++;
      if (obs !== 12'h000) begin
        errors++;
        $display("FAIL pre_reset k=%0d got=%h exp=%h", k, obs, 12'h000);
      end
      if (k == 3) sw[8] = 1'b1;
    end
    // Debounce is now mid-confirm; abort it with an asynchronous reset.
    reset = 1'b1;
    sw    = 10'h215;
    #1;
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (obs !== 12'h000) begin
        errors++;
        $display("FAIL in_reset j=%0d got=%h exp=%h", j, obs, 12'h000);
      end
      step();
    end
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp = {1'b0, (k >= 9), (k == 9), 1'b0,
             (k >= 9) ? 4'd1 : 4'd0, (k >= 9) ? 4'd5 : 4'd0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL post_reset_press k=%0d got=%h exp=%h", k, obs, exp);
      end
      if (k == 3) sw[8] = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_set_hour();
    test_validation();
    test_bounce();
    test_held_glitch();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
